// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - register file port bundle: read/write indices, data and write-back counter
interface register_file_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 8
);
    logic [ADDR_WIDTH-1:0] read_reg1;
    logic [ADDR_WIDTH-1:0] read_reg2;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  regwrite;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;
    logic [CNT_WIDTH-1:0]  wb_count;

    modport master (
        output read_reg1, read_reg2, write_reg, write_data, regwrite,
        input  read_data1, read_data2, wb_count
    );

    modport slave (
        input  read_reg1, read_reg2, write_reg, write_data, regwrite,
        output read_data1, read_data2, wb_count
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 8x8 register file, R0 hardwired zero, saturating write-back counter; REGFILE_BYPASS_EN adds write-through
module register_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 8
) (
    input logic           clk,
    input logic           reset,
    register_file_if.slave rf
);
    localparam int REG_COUNT = 2 ** ADDR_WIDTH;

    // R0 has no storage, so the array starts at index 1.
    logic [DATA_WIDTH-1:0] regs [1:REG_COUNT-1];
    logic [CNT_WIDTH-1:0]  wb_count_q;
    logic                  commit;

    assign commit = rf.regwrite && (rf.write_reg != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs       <= '{default: '0};
            wb_count_q <= '0;
        end else if (commit) begin
            regs[rf.write_reg] <= rf.write_data;
            if (wb_count_q != '1) begin
                wb_count_q <= wb_count_q + 1'b1;
            end
        end
    end

    always_comb begin
        rf.read_data1 = (rf.read_reg1 == '0) ? '0 : regs[rf.read_reg1];
        rf.read_data2 = (rf.read_reg2 == '0) ? '0 : regs[rf.read_reg2];
`ifdef REGFILE_BYPASS_EN
        // commit already excludes R0, so a match never forwards into R0.
        if (commit && (rf.read_reg1 == rf.write_reg)) begin
            rf.read_data1 = rf.write_data;
        end
        if (commit && (rf.read_reg2 == rf.write_reg)) begin
            rf.read_data2 = rf.write_data;
        end
`endif
    end

    assign rf.wb_count = wb_count_q;
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized self-checking bench for register_file against an array model
module tb_register_file;
    logic clk;
    logic reset;
    int   checks_count;
    int   error_count;

    int model_regs [8];
    int model_cnt;

    register_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .CNT_WIDTH(8)) rf_bus ();

    register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_read(input int idx);
        if (idx == 0) return 0;
`ifdef REGFILE_BYPASS_EN
        if (rf_bus.regwrite && rf_bus.write_reg != 0 && idx == int'(rf_bus.write_reg))
            return int'(rf_bus.write_data);
`endif
        return model_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_regs[i] = 0;
        model_cnt = 0;
    endtask

    // One rising edge; the model commits using the inputs held across that edge.
    task automatic tick();
        bit commit;
        int wr;
        int wd;
        commit = !reset && rf_bus.regwrite && rf_bus.write_reg != 0;
        wr     = int'(rf_bus.write_reg);
        wd     = int'(rf_bus.write_data);
        @(posedge clk);
        if (commit) begin
            model_regs[wr] = wd;
            if (model_cnt < 255) model_cnt++;
        end
        #1;
    endtask

    task automatic write_reg_t(input int idx, input int data);
        rf_bus.regwrite   = 1'b1;
        rf_bus.write_reg  = 3'(idx);
        rf_bus.write_data = 8'(data);
        tick();
        rf_bus.regwrite   = 1'b0;
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_rd1"}, 32'(rf_bus.read_data1), 32'(exp_read(int'(rf_bus.read_reg1))));
        check({tag, "_rd2"}, 32'(rf_bus.read_data2), 32'(exp_read(int'(rf_bus.read_reg2))));
        check({tag, "_cnt"}, 32'(rf_bus.wb_count), 32'(model_cnt));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks_count = 0;
        error_count  = 0;
        rf_bus.read_reg1  = '0;
        rf_bus.read_reg2  = '0;
        rf_bus.write_reg  = '0;
        rf_bus.write_data = '0;
        rf_bus.regwrite   = 1'b0;
        do_reset();

        // Reset state on every register.
        for (int i = 0; i < 8; i++) begin
            rf_bus.read_reg1 = 3'(i);
            rf_bus.read_reg2 = 3'(7 - i);
            #1;
            check("reset_rd1", 32'(rf_bus.read_data1), 32'h0);
            check("reset_rd2", 32'(rf_bus.read_data2), 32'h0);
        end
        check("reset_cnt", 32'(rf_bus.wb_count), 32'h0);

        // Asynchronous reset mid-cycle after R3=0x5A.
        write_reg_t(3, 8'h5A);
        rf_bus.read_reg1 = 3'd3;
        rf_bus.read_reg2 = 3'd3;
        #1;
        check("pre_async_rd1", 32'(rf_bus.read_data1), 32'h5A);
        check("pre_async_cnt", 32'(rf_bus.wb_count), 32'h1);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rd1", 32'(rf_bus.read_data1), 32'h0);
        check("async_rd2", 32'(rf_bus.read_data2), 32'h0);
        check("async_cnt", 32'(rf_bus.wb_count), 32'h0);
        // A write on an edge while reset is held is lost.
        rf_bus.regwrite   = 1'b1;
        rf_bus.write_reg  = 3'd3;
        rf_bus.write_data = 8'h77;
        tick();
        check("wr_in_reset_rd1", 32'(rf_bus.read_data1), 32'h0);
        check("wr_in_reset_cnt", 32'(rf_bus.wb_count), 32'h0);
        reset = 1'b0;
        tick();
        rf_bus.regwrite = 1'b0;
        #1;
        check("first_after_reset", 32'(rf_bus.read_data1), 32'h77);
        check("first_after_cnt", 32'(rf_bus.wb_count), 32'h1);

        // Basic write and read.
        do_reset();
        write_reg_t(5, 8'h0E);
        write_reg_t(2, 8'h16);
        rf_bus.read_reg1 = 3'd5;
        rf_bus.read_reg2 = 3'd2;
        #1;
        check("basic_rd1", 32'(rf_bus.read_data1), 32'h0E);
        check("basic_rd2", 32'(rf_bus.read_data2), 32'h16);
        check("basic_cnt", 32'(rf_bus.wb_count), 32'h2);

        // R0 protection.
        write_reg_t(0, 8'hFF);
        rf_bus.read_reg1 = 3'd0;
        rf_bus.read_reg2 = 3'd0;
        #1;
        check("r0_rd1", 32'(rf_bus.read_data1), 32'h0);
        check("r0_rd2", 32'(rf_bus.read_data2), 32'h0);
        check("r0_cnt", 32'(rf_bus.wb_count), 32'h2);

        // Same-cycle read/write hazard on R4.
        write_reg_t(4, 8'h11);
        rf_bus.read_reg1  = 3'd4;
        rf_bus.regwrite   = 1'b1;
        rf_bus.write_reg  = 3'd4;
        rf_bus.write_data = 8'h1E;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hazard_pre", 32'(rf_bus.read_data1), 32'h1E);
`else
        check("hazard_pre", 32'(rf_bus.read_data1), 32'h11);
`endif
        tick();
        rf_bus.regwrite = 1'b0;
        #1;
        check("hazard_post", 32'(rf_bus.read_data1), 32'h1E);

        // Gated write: regwrite low for three edges.
        rf_bus.regwrite   = 1'b0;
        rf_bus.write_reg  = 3'd6;
        rf_bus.write_data = 8'hAA;
        rf_bus.read_reg2  = 3'd6;
        repeat (3) tick();
        check("gated_rd2", 32'(rf_bus.read_data2), 32'h0);
        check("gated_cnt", 32'(rf_bus.wb_count), 32'h4);

        // Randomized traffic, checked before and after each edge.
        for (int n = 0; n < 300; n++) begin
            rf_bus.read_reg1  = 3'($urandom_range(0, 7));
            rf_bus.read_reg2  = 3'($urandom_range(0, 7));
            rf_bus.write_reg  = 3'($urandom_range(0, 7));
            rf_bus.write_data = 8'($urandom);
            rf_bus.regwrite   = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) rf_bus.read_reg1 = rf_bus.write_reg;
            #1;
            check_ports("rand_pre");
            tick();
            check_ports("rand_post");
        end
        rf_bus.regwrite = 1'b0;

        // Counter saturation over 260 committed writes.
        do_reset();
        for (int n = 1; n <= 260; n++) begin
            write_reg_t(1 + (n % 7), n);
            if (n == 254) check("sat_254", 32'(rf_bus.wb_count), 32'hFE);
            if (n == 255) check("sat_255", 32'(rf_bus.wb_count), 32'hFF);
            if (n == 258) check("sat_258", 32'(rf_bus.wb_count), 32'hFF);
        end
        check("sat_260", 32'(rf_bus.wb_count), 32'hFF);
        check("sat_model", 32'(rf_bus.wb_count), 32'(model_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks_count, error_count);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
